map_move_checker: RTL and testbench



---
 rtl/map_move_if.sv | 26 ++
 rtl/map_move_checker.sv | 113 +++++++++++
 tb/tb_map_move_checker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/map_move_if.sv
// map_move_if: level-load, wall-map and move-request signals between game logic and map_move_checker.
interface map_move_if #(
  parameter int COLS = 15,
  parameter int ROWS = 10
);
  logic                 level_load;
  logic [COLS*ROWS-1:0] map;
  logic                 req;
  logic [3:0]           cur_x;
  logic [3:0]           cur_y;
  logic [1:0]           dir;
  logic                 ack;
  logic                 allowed;
  logic [3:0]           new_x;
  logic [3:0]           new_y;
  logic                 map_valid;
  logic                 busy;
  modport master (
    output level_load, map, req, cur_x, cur_y, dir,
    input  ack, allowed, new_x, new_y, map_valid, busy
  );
  modport slave (
    input  level_load, map, req, cur_x, cur_y, dir,
    output ack, allowed, new_x, new_y, map_valid, busy
  );
endinterface

// File: rtl/map_move_checker.sv
// map_move_checker: snapshots the level wall map after a ROM load and answers tile move requests.
module map_move_checker #(
  parameter int COLS        = 15,
  parameter int ROWS        = 10,
  parameter int ROM_LATENCY = 1
) (
  input logic       clk,
  input logic       rst,
  map_move_if.slave bus
);
  localparam int N  = COLS * ROWS;
  localparam int IW = $clog2(N);
  localparam int CW = ROM_LATENCY < 2 ? 1 : $clog2(ROM_LATENCY + 1);
  localparam logic signed [4:0] SC = 5'(COLS);
  localparam logic signed [4:0] SR = 5'(ROWS);
  typedef enum logic [1:0] {EMPTY, LOAD_WAIT, READY, CHECK} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  snap_q, snap_d;
  logic [3:0]    lx_q, lx_d, ly_q, ly_d, nx_q, nx_d, ny_q, ny_d;
  logic [1:0]    ldir_q, ldir_d;
  logic          mv_q, mv_d, ack_q, ack_d, allowed_q, allowed_d;
  logic signed [4:0] tx, ty;
  logic          in_grid, tgt_in, ok;
  logic [IW-1:0] idx;
  // Target math in 5-bit signed so x=0 going left becomes -1 rather than 15.
  always_comb begin
    tx      = $signed({1'b0, lx_q}) + (ldir_q == 2'd2 ? -5'sd1 : ldir_q == 2'd3 ? 5'sd1 : 5'sd0);
    ty      = $signed({1'b0, ly_q}) + (ldir_q == 2'd0 ? -5'sd1 : ldir_q == 2'd1 ? 5'sd1 : 5'sd0);
    in_grid = $signed({1'b0, lx_q}) < SC && $signed({1'b0, ly_q}) < SR;
    tgt_in  = tx >= 5'sd0 && tx < SC && ty >= 5'sd0 && ty < SR;
    idx     = tgt_in ? IW'(N - 1) - (IW'(ty[3:0]) * IW'(COLS) + IW'(tx[3:0])) : '0;
    ok      = in_grid && tgt_in && !snap_q[idx];
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    mv_d      = mv_q;
    ack_d     = 1'b0;
    allowed_d = allowed_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    lx_d      = lx_q;
    ly_d      = ly_q;
    ldir_d    = ldir_q;
    if (bus.level_load) begin
      state_d = LOAD_WAIT;
      cnt_d   = CW'(ROM_LATENCY);
      mv_d    = 1'b0;
    end else begin
      case (state_q)
        LOAD_WAIT: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            snap_d  = bus.map;
            mv_d    = 1'b1;
            state_d = READY;
          end
        end
        READY: begin
          if (bus.req) begin
            lx_d    = bus.cur_x;
            ly_d    = bus.cur_y;
            ldir_d  = bus.dir;
            state_d = CHECK;
          end
        end
        CHECK: begin
          allowed_d = ok;
          nx_d      = ok ? tx[3:0] : lx_q;
          ny_d      = ok ? ty[3:0] : ly_q;
          ack_d     = 1'b1;
          state_d   = READY;
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      snap_q    <= '0;
      mv_q      <= 1'b0;
      ack_q     <= 1'b0;
      allowed_q <= 1'b0;
      nx_q      <= '0;
      ny_q      <= '0;
      lx_q      <= '0;
      ly_q      <= '0;
      ldir_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      mv_q      <= mv_d;
      ack_q     <= ack_d;
      allowed_q <= allowed_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      ldir_q    <= ldir_d;
    end
  end
  assign bus.ack       = ack_q;
  assign bus.allowed   = allowed_q;
  assign bus.new_x     = nx_q;
  assign bus.new_y     = ny_q;
  assign bus.map_valid = mv_q;
  assign bus.busy      = state_q == LOAD_WAIT || state_q == CHECK;
endmodule

// File: tb/tb_map_move_checker.sv
// tb_map_move_checker: directed scenarios with hand-computed results for map_move_checker.
module tb_map_move_checker;
  logic clk;
  logic rst;
  int   vecs;
  int   miss;
  map_move_if #(.COLS(15), .ROWS(10)) bus();
  map_move_checker #(.COLS(15), .ROWS(10), .ROM_LATENCY(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d, output int lat);
    bus.cur_x = x;
    bus.cur_y = y;
    bus.dir   = d;
    bus.req   = 1'b1;
    tick();
    bus.req = 1'b0;
    lat = 1;
    while (bus.ack !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
  endtask
  task automatic do_load(input logic [149:0] m);
    bus.map        = m;
    bus.level_load = 1'b1;
    tick();
    bus.level_load = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    int lat;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vecs++; if ({bus.ack, bus.allowed, bus.new_x, bus.new_y, bus.map_valid, bus.busy} !== 12'h0) begin miss++; $display("FAIL reset_outputs: got %b want 0", {bus.ack, bus.allowed, bus.new_x, bus.new_y, bus.map_valid, bus.busy}); end
    do_req(4'd7, 4'd5, 2'd3, lat);
    vecs++; if (lat !== 6) begin miss++; $display("FAIL req_before_map: ack after %0d cycles, want none", lat); end
    vecs++; if ({bus.allowed, bus.new_x, bus.new_y, bus.map_valid, bus.busy} !== 11'h0) begin miss++; $display("FAIL idle_outputs: got %b want 0", {bus.allowed, bus.new_x, bus.new_y, bus.map_valid, bus.busy}); end
  endtask
  task automatic test_free();
    int lat;
    do_load('0);
    vecs++; if (bus.map_valid !== 1'b1 || bus.busy !== 1'b0) begin miss++; $display("FAIL load_done: map_valid=%b busy=%b want 1 0", bus.map_valid, bus.busy); end
    do_req(4'd7, 4'd5, 2'd3, lat);
    vecs++; if (lat !== 2) begin miss++; $display("FAIL free_latency: got %0d want 2", lat); end
    vecs++; if ({bus.allowed, bus.new_x, bus.new_y} !== {1'b1, 4'd8, 4'd5}) begin miss++; $display("FAIL free_result: got %b,%0d,%0d want 1,8,5", bus.allowed, bus.new_x, bus.new_y); end
  endtask
  task automatic test_back_to_back();
    int lat;
    do_req(4'd2, 4'd3, 2'd1, lat);
    vecs++; if (lat !== 2 || {bus.allowed, bus.new_x, bus.new_y} !== {1'b1, 4'd2, 4'd4}) begin miss++; $display("FAIL b2b_first: lat=%0d got %b,%0d,%0d want 2 1,2,4", lat, bus.allowed, bus.new_x, bus.new_y); end
    do_req(4'd2, 4'd4, 2'd0, lat);
    vecs++; if (lat !== 2 || {bus.allowed, bus.new_x, bus.new_y} !== {1'b1, 4'd2, 4'd3}) begin miss++; $display("FAIL b2b_second: lat=%0d got %b,%0d,%0d want 2 1,2,3", lat, bus.allowed, bus.new_x, bus.new_y); end
    tick();
    vecs++; if (bus.ack !== 1'b0) begin miss++; $display("FAIL ack_pulse: ack=%b want 0", bus.ack); end
  endtask
  task automatic run_table(input string name, input int v[6][6], input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      do_req(4'(v[i][0]), 4'(v[i][1]), 2'(v[i][2]), lat);
      vecs++; if (lat !== 2 || bus.allowed !== 1'(v[i][3]) || bus.new_x !== 4'(v[i][4]) || bus.new_y !== 4'(v[i][5])) begin miss++; $display("FAIL %s[%0d]: lat=%0d got %b,%0d,%0d want 2 %0d,%0d,%0d", name, i, lat, bus.allowed, bus.new_x, bus.new_y, v[i][3], v[i][4], v[i][5]); end
    end
  endtask
  task automatic test_wall();
    logic [149:0] m;
    int w[6][6] = '{'{7,5,3,0,7,5}, '{7,5,2,1,6,5}, '{8,4,1,0,8,4}, '{8,6,0,0,8,6}, '{9,5,2,0,9,5}, '{8,5,3,1,9,5}};
    int c[6][6] = '{'{1,0,2,0,1,0}, '{0,1,0,0,0,1}, '{13,9,3,0,13,9}, '{14,8,1,0,14,8}, '{1,0,3,1,2,0}, '{7,5,3,1,8,5}};
    m = '0;
    m[66] = 1'b1;
    do_load(m);
    run_table("wall66", w, 6);
    m = '0;
    m[149] = 1'b1;
    m[0] = 1'b1;
    do_load(m);
    run_table("corners", c, 6);
  endtask
  task automatic test_edges();
    int a[6][6] = '{'{0,0,0,0,0,0}, '{0,0,2,0,0,0}, '{14,9,1,0,14,9}, '{14,9,3,0,14,9}, '{0,1,0,1,0,0}, '{13,9,3,1,14,9}};
    int b[6][6] = '{'{15,3,2,0,15,3}, '{3,10,0,0,3,10}, '{15,15,1,0,15,15}, '{14,0,3,0,14,0}, '{0,9,1,0,0,9}, '{14,5,2,1,13,5}};
    do_load('0);
    run_table("edges", a, 6);
    run_table("range", b, 6);
  endtask
  task automatic test_load_and_req();
    logic [149:0] m;
    int lat;
    m = '0;
    m[66] = 1'b1;
    bus.map        = m;
    bus.level_load = 1'b1;
    bus.req        = 1'b1;
    bus.cur_x      = 4'd7;
    bus.cur_y      = 4'd5;
    bus.dir        = 2'd3;
    tick();
    bus.level_load = 1'b0;
    bus.req        = 1'b0;
    vecs++; if (bus.ack !== 1'b0 || bus.map_valid !== 1'b0 || bus.busy !== 1'b1) begin miss++; $display("FAIL load_req_n1: ack=%b mv=%b busy=%b want 0 0 1", bus.ack, bus.map_valid, bus.busy); end
    tick();
    vecs++; if (bus.ack !== 1'b0 || bus.map_valid !== 1'b1 || bus.busy !== 1'b0) begin miss++; $display("FAIL load_req_n2: ack=%b mv=%b busy=%b want 0 1 0", bus.ack, bus.map_valid, bus.busy); end
    do_req(4'd7, 4'd5, 2'd3, lat);
    vecs++; if (lat !== 2 || {bus.allowed, bus.new_x, bus.new_y} !== {1'b0, 4'd7, 4'd5}) begin miss++; $display("FAIL load_req_newmap: lat=%0d got %b,%0d,%0d want 2 0,7,5", lat, bus.allowed, bus.new_x, bus.new_y); end
  endtask
  task automatic test_restart();
    bus.map = '0;
    bus.level_load = 1'b1;
    tick();
    vecs++; if (bus.map_valid !== 1'b0 || bus.busy !== 1'b1) begin miss++; $display("FAIL restart_n1: mv=%b busy=%b want 0 1", bus.map_valid, bus.busy); end
    tick();
    bus.level_load = 1'b0;
    vecs++; if (bus.map_valid !== 1'b0 || bus.busy !== 1'b1) begin miss++; $display("FAIL restart_n2: mv=%b busy=%b want 0 1", bus.map_valid, bus.busy); end
    tick();
    vecs++; if (bus.map_valid !== 1'b1 || bus.busy !== 1'b0) begin miss++; $display("FAIL restart_n3: mv=%b busy=%b want 1 0", bus.map_valid, bus.busy); end
  endtask
  task automatic test_abort();
    int acks;
    acks = 0;
    bus.cur_x = 4'd4;
    bus.cur_y = 4'd4;
    bus.dir   = 2'd3;
    bus.req   = 1'b1;
    tick();
    bus.req = 1'b0;
    bus.level_load = 1'b1;
    vecs++; if (bus.busy !== 1'b1) begin miss++; $display("FAIL abort_check: busy=%b want 1", bus.busy); end
    tick();
    bus.level_load = 1'b0;
    vecs++; if (bus.ack !== 1'b0 || bus.map_valid !== 1'b0 || bus.busy !== 1'b1) begin miss++; $display("FAIL abort_n2: ack=%b mv=%b busy=%b want 0 0 1", bus.ack, bus.map_valid, bus.busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ack === 1'b1) acks++;
    end
    vecs++; if (acks !== 0 || bus.map_valid !== 1'b1) begin miss++; $display("FAIL abort_after: acks=%0d mv=%b want 0 1", acks, bus.map_valid); end
  endtask
  task automatic test_reset_mid();
    int lat;
    bus.map = '0;
    bus.level_load = 1'b1;
    tick();
    bus.level_load = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++; if (bus.map_valid !== 1'b0 || bus.busy !== 1'b0) begin miss++; $display("FAIL rst_mid: mv=%b busy=%b want 0 0", bus.map_valid, bus.busy); end
    tick();
    tick();
    vecs++; if (bus.map_valid !== 1'b0 || bus.busy !== 1'b0) begin miss++; $display("FAIL rst_mid_hold: mv=%b busy=%b want 0 0", bus.map_valid, bus.busy); end
    do_req(4'd7, 4'd5, 2'd3, lat);
    vecs++; if (lat !== 6 || {bus.allowed, bus.new_x, bus.new_y} !== 9'h0) begin miss++; $display("FAIL rst_mid_req: lat=%0d got %b,%0d,%0d want none 0,0,0", lat, bus.allowed, bus.new_x, bus.new_y); end
  endtask
  initial begin
    vecs = 0;
    miss = 0;
    rst = 1'b1;
    bus.level_load = 1'b0;
    bus.map = '0;
    bus.req = 1'b0;
    bus.cur_x = '0;
    bus.cur_y = '0;
    bus.dir = '0;
    test_reset();
    test_free();
    test_back_to_back();
    test_wall();
    test_edges();
    test_load_and_req();
    test_restart();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
